// File: rtl/instr_ram_arbiter_if.sv
// Bus bundle between the two instruction-memory masters, the arbiter and the memory.
// slave: the arbiter's view; master: the surrounding environment's view.
interface instr_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [BE_WIDTH-1:0]   m1_be;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_err;

  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [BE_WIDTH-1:0]   ram_be;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_addr,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output ram_en, ram_addr, ram_wdata, ram_we, ram_be,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_addr,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  ram_en, ram_addr, ram_wdata, ram_we, ram_be,
    output ram_rdata
  );
endinterface

// File: rtl/instr_ram_arbiter.sv
// Fixed-priority arbiter (fetch first, loader protected from starvation) for the shared
// single-port instruction RAM / boot ROM, with response routing and boot-ROM write protection.
module instr_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  instr_ram_arbiter_if.slave bus
);
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 starve_full;
  logic                 m0_win;
  logic                 m1_win;
  logic                 rom_write;
  logic                 rsp_valid_q;
  logic                 rsp_owner_q;
  logic                 rsp_err_q;

  // Loader wins when fetch is idle or the loader has waited STARVE_LIMIT cycles.
  assign starve_full = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));
  assign m1_win      = bus.m1_req & (~bus.m0_req | starve_full);
  assign m0_win      = bus.m0_req & ~m1_win;
  assign rom_write   = m1_win & bus.m1_we & bus.m1_addr[ADDR_WIDTH-1];

  assign bus.m0_gnt  = m0_win;
  assign bus.m1_gnt  = m1_win;

  // Memory drive; a boot-ROM write is accepted but never reaches the memory.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_be    = '0;
    if (m1_win) begin
      bus.ram_en    = ~rom_write;
      bus.ram_we    = bus.m1_we & ~rom_write;
      bus.ram_addr  = bus.m1_addr;
      bus.ram_wdata = bus.m1_wdata;
      bus.ram_be    = bus.m1_be;
    end else if (m0_win) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = bus.m0_addr;
      bus.ram_be    = {BE_WIDTH{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (bus.m1_req && !m1_win) begin
      if (!starve_full) starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // One outstanding response per cycle, returned exactly one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= m0_win | m1_win;
      rsp_owner_q <= m1_win;
      rsp_err_q   <= rom_write;
    end
  end

  assign bus.m0_rvalid = rsp_valid_q & ~rsp_owner_q;
  assign bus.m1_rvalid = rsp_valid_q & rsp_owner_q;
  assign bus.m1_err    = rsp_valid_q & rsp_owner_q & rsp_err_q;
  assign bus.m0_rdata  = bus.ram_rdata;
  assign bus.m1_rdata  = bus.ram_rdata;

endmodule
